// File: rtl/tone_generator_if.sv
// Player-side bundle for the tone generator: play gate, note/octave request,
// and the buzzer drive plus status returned by the generator.
interface tone_generator_if;
    logic       enable;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       buzzer;
    logic       tone_active;
    logic [3:0] cur_note;
    logic [1:0] cur_oct;

    modport master (
        output enable, note_in, octave_in,
        input  buzzer, tone_active, cur_note, cur_oct
    );

    modport slave (
        input  enable, note_in, octave_in,
        output buzzer, tone_active, cur_note, cur_oct
    );
endinterface

// File: rtl/tone_generator.sv
// Square-wave buzzer driver: plays notes C..B in three octaves, switching pitch
// or going silent only on half-period boundaries so no pulse is ever truncated.
module tone_generator #(
    parameter int COUNT_SHIFT = 0
) (
    input  logic             clk,
    input  logic             reset,
    tone_generator_if.slave  bus
);

    localparam logic [0:0] ST_SILENT = 1'b0;
    localparam logic [0:0] ST_TONE   = 1'b1;

    logic [0:0]  r_state;
    logic [3:0]  r_cur_note;
    logic [1:0]  r_cur_oct;
    logic [19:0] r_half_cnt;
    logic [19:0] r_cnt;
    logic        r_buzzer;

    logic [19:0] w_base;
    logic [19:0] w_oct_half;
    logic [19:0] w_half;
    logic        w_note_valid;
    logic        w_boundary;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_base     = 20'd0;
        w_oct_half = 20'd0;
        case (bus.note_in)
            4'd1:    w_base = 20'd191110;
            4'd2:    w_base = 20'd170262;
            4'd3:    w_base = 20'd151685;
            4'd4:    w_base = 20'd143172;
            4'd5:    w_base = 20'd127551;
            4'd6:    w_base = 20'd113636;
            4'd7:    w_base = 20'd101239;
            default: w_base = 20'd0;
        endcase
        case (bus.octave_in)
            2'd0:    w_oct_half = w_base << 1;
            2'd2:    w_oct_half = w_base >> 1;
            default: w_oct_half = w_base;
        endcase
        w_half = w_oct_half >> COUNT_SHIFT;
        // A half count below 2 would make the boundary compare degenerate.
        if (w_half < 20'd2) w_half = 20'd2;
    end

    assign w_note_valid = (bus.note_in >= 4'd1) && (bus.note_in <= 4'd7);
    assign w_boundary   = (r_cnt == r_half_cnt - 20'd1);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_SILENT;
            r_cur_note <= 4'd0;
            r_cur_oct  <= 2'd1;
            r_half_cnt <= 20'd0;
            r_cnt      <= 20'd0;
            r_buzzer   <= 1'b0;
        end else if (!bus.enable) begin
            r_state    <= ST_SILENT;
            r_cur_note <= 4'd0;
            r_cnt      <= 20'd0;
            r_buzzer   <= 1'b0;
        end else begin
            case (r_state)
                ST_SILENT: begin
                    r_cnt    <= 20'd0;
                    r_buzzer <= 1'b0;
                    if (w_note_valid) begin
                        r_state    <= ST_TONE;
                        r_cur_note <= bus.note_in;
                        r_cur_oct  <= bus.octave_in;
                        r_half_cnt <= w_half;
                        r_buzzer   <= 1'b1;
                    end
                end
                default: begin
                    if (w_boundary) begin
                        r_cnt <= 20'd0;
                        if (w_note_valid) begin
                            r_buzzer   <= ~r_buzzer;
                            r_cur_note <= bus.note_in;
                            r_cur_oct  <= bus.octave_in;
                            r_half_cnt <= w_half;
                        end else begin
                            r_state    <= ST_SILENT;
                            r_cur_note <= 4'd0;
                            r_buzzer   <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
            endcase
        end
    end

    assign bus.buzzer      = r_buzzer;
    assign bus.tone_active = (r_state == ST_TONE);
    assign bus.cur_note    = r_cur_note;
    assign bus.cur_oct     = r_cur_oct;

endmodule

// File: tb/tb_tone_generator.sv
// Directed bench for tone_generator: a COUNT_SHIFT=10 instance for pitch and
// sequencing behaviour and a COUNT_SHIFT=0 instance for one full-scale half-period.
module tb_tone_generator;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    tone_generator_if bus0 ();
    tone_generator_if bus1 ();

    tone_generator #(.COUNT_SHIFT(10)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    tone_generator #(.COUNT_SHIFT(0))  dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count negedge samples until the buzzer of the selected instance changes.
    task automatic phase_len(input bit sel, output int n);
        logic v;
        v = sel ? bus1.buzzer : bus0.buzzer;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((sel ? bus1.buzzer : bus0.buzzer) == v) && (n < 60000));
    endtask

    // Silence dut0 for one cycle, then request a new note; returns at the first
    // sample of the new tone's high phase.
    task automatic restart(input logic [3:0] note, input logic [1:0] oct);
        @(negedge clk);
        bus0.enable = 1'b0;
        @(negedge clk);
        bus0.enable    = 1'b1;
        bus0.note_in   = note;
        bus0.octave_in = oct;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus0.enable = 1'b1; bus0.note_in = 4'd1; bus0.octave_in = 2'd2;
        bus1.enable = 1'b0; bus1.note_in = 4'd0; bus1.octave_in = 2'd1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus0.buzzer !== 1'b0 || bus0.tone_active !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: buzzer=%b tone_active=%b, expected 0 0", bus0.buzzer, bus0.tone_active);
        end
        checks++;
        if (bus0.cur_note !== 4'd0 || bus0.cur_oct !== 2'd1) begin
            failures++;
            $display("FAIL reset_state: cur_note=%0d cur_oct=%0d, expected 0 1", bus0.cur_note, bus0.cur_oct);
        end
        reset = 1'b0;
        bus0.enable = 1'b0; bus0.note_in = 4'd0; bus0.octave_in = 2'd1;
        @(negedge clk);
    endtask

    task automatic test_start;
        int n;
        bus0.enable = 1'b1; bus0.note_in = 4'd0; bus0.octave_in = 2'd1;
        @(negedge clk);
        checks++;
        if (bus0.tone_active !== 1'b0) begin
            failures++;
            $display("FAIL rest_stays_silent: tone_active=%b expected 0", bus0.tone_active);
        end
        bus0.note_in = 4'd1;
        @(negedge clk);
        checks++;
        if (bus0.tone_active !== 1'b1 || bus0.buzzer !== 1'b1 || bus0.cur_note !== 4'd1) begin
            failures++;
            $display("FAIL start_latency: tone_active=%b buzzer=%b cur_note=%0d, expected 1 1 1",
                     bus0.tone_active, bus0.buzzer, bus0.cur_note);
        end
        phase_len(1'b0, n);
        checks++;
        if (n != 186) begin
            failures++;
            $display("FAIL note1_high_phase: got %0d expected 186", n);
        end
        phase_len(1'b0, n);
        checks++;
        if (n != 186) begin
            failures++;
            $display("FAIL note1_low_phase: got %0d expected 186", n);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int total;
        restart(4'd7, 2'd1);
        total = 0;
        for (int i = 0; i < 4; i++) begin
            phase_len(1'b0, n);
            total += n;
            checks++;
            if (n != 98) begin
                failures++;
                $display("FAIL repeat_phase_%0d: got %0d expected 98", i, n);
            end
        end
        checks++;
        if (total != 392) begin
            failures++;
            $display("FAIL repeat_two_periods: got %0d expected 392", total);
        end
    endtask

    task automatic test_pitch_change;
        int n;
        restart(4'd6, 2'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 40) bus0.octave_in = 2'd2;
            if (n == 41) begin
                checks++;
                if (bus0.cur_oct !== 2'd1) begin
                    failures++;
                    $display("FAIL octave_held_midphase: cur_oct=%0d expected 1", bus0.cur_oct);
                end
            end
        end while (bus0.buzzer == 1'b1 && n < 1000);
        checks++;
        if (n != 110) begin
            failures++;
            $display("FAIL pitch_change_first_half: got %0d expected 110", n);
        end
        phase_len(1'b0, n);
        checks++;
        if (n != 55 || bus0.cur_oct !== 2'd2) begin
            failures++;
            $display("FAIL pitch_change_new_half: got %0d oct=%0d expected 55 oct=2", n, bus0.cur_oct);
        end
    endtask

    task automatic test_rest;
        int n;
        bus0.note_in = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 10) begin
                checks++;
                if (bus0.buzzer !== 1'b1 || bus0.cur_note !== 4'd6) begin
                    failures++;
                    $display("FAIL rest_holds_phase: buzzer=%b cur_note=%0d, expected 1 6", bus0.buzzer, bus0.cur_note);
                end
            end
        end while (bus0.tone_active == 1'b1 && n < 500);
        checks++;
        if (n != 55 || bus0.buzzer !== 1'b0 || bus0.cur_note !== 4'd0) begin
            failures++;
            $display("FAIL rest_at_boundary: cycles=%0d buzzer=%b cur_note=%0d, expected 55 0 0",
                     n, bus0.buzzer, bus0.cur_note);
        end
    endtask

    task automatic test_enable_drop;
        int n;
        bus0.note_in = 4'd3; bus0.octave_in = 2'd1;
        @(negedge clk);
        repeat (20) @(negedge clk);
        bus0.enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.buzzer !== 1'b0 || bus0.tone_active !== 1'b0 || bus0.cur_note !== 4'd0) begin
            failures++;
            $display("FAIL enable_drop: buzzer=%b tone_active=%b cur_note=%0d, expected 0 0 0",
                     bus0.buzzer, bus0.tone_active, bus0.cur_note);
        end
        bus0.enable = 1'b1;
        @(negedge clk);
        checks++;
        if (bus0.buzzer !== 1'b1 || bus0.tone_active !== 1'b1 || bus0.cur_note !== 4'd3) begin
            failures++;
            $display("FAIL enable_restart: buzzer=%b tone_active=%b cur_note=%0d, expected 1 1 3",
                     bus0.buzzer, bus0.tone_active, bus0.cur_note);
        end
        phase_len(1'b0, n);
        checks++;
        if (n != 148) begin
            failures++;
            $display("FAIL note3_half: got %0d expected 148", n);
        end
    endtask

    task automatic test_enable_at_boundary;
        restart(4'd7, 2'd1);
        repeat (97) @(negedge clk);
        bus0.enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.tone_active !== 1'b0 || bus0.buzzer !== 1'b0) begin
            failures++;
            $display("FAIL enable_wins_boundary: tone_active=%b buzzer=%b, expected 0 0", bus0.tone_active, bus0.buzzer);
        end
    endtask

    task automatic test_octaves;
        int n;
        restart(4'd5, 2'd3);
        phase_len(1'b0, n);
        checks++;
        if (n != 124) begin
            failures++;
            $display("FAIL note5_oct3: got %0d expected 124", n);
        end
        restart(4'd5, 2'd1);
        phase_len(1'b0, n);
        checks++;
        if (n != 124) begin
            failures++;
            $display("FAIL note5_oct1: got %0d expected 124", n);
        end
        restart(4'd5, 2'd0);
        phase_len(1'b0, n);
        checks++;
        if (n != 249) begin
            failures++;
            $display("FAIL note5_oct0: got %0d expected 249", n);
        end
        bus0.enable = 1'b0;
    endtask

    task automatic test_full_scale;
        int n;
        @(negedge clk);
        bus1.enable = 1'b1; bus1.note_in = 4'd7; bus1.octave_in = 2'd2;
        @(negedge clk);
        checks++;
        if (bus1.buzzer !== 1'b1) begin
            failures++;
            $display("FAIL full_scale_start: buzzer=%b expected 1", bus1.buzzer);
        end
        phase_len(1'b1, n);
        checks++;
        if (n != 50619) begin
            failures++;
            $display("FAIL full_scale_half: got %0d expected 50619", n);
        end
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus1.buzzer !== 1'b0 || bus1.tone_active !== 1'b0 || bus1.cur_note !== 4'd0 || bus1.cur_oct !== 2'd1) begin
            failures++;
            $display("FAIL reset_mid_tone: buzzer=%b tone_active=%b cur_note=%0d cur_oct=%0d, expected 0 0 0 1",
                     bus1.buzzer, bus1.tone_active, bus1.cur_note, bus1.cur_oct);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus1.buzzer !== 1'b1 || bus1.tone_active !== 1'b1 || bus1.cur_note !== 4'd7) begin
            failures++;
            $display("FAIL restart_after_reset: buzzer=%b tone_active=%b cur_note=%0d, expected 1 1 7",
                     bus1.buzzer, bus1.tone_active, bus1.cur_note);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        test_reset();
        test_start();
        test_back_to_back();
        test_pitch_change();
        test_rest();
        test_enable_drop();
        test_enable_at_boundary();
        test_octaves();
        test_full_scale();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
